// File: rtl/xor_stream_decoder_if.sv
`default_nettype none
// =============================================================================
// xor_stream_decoder_if : encoded-in / decoded-out handshake bundle
// Revision 1.0
// =============================================================================
interface xor_stream_decoder_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             frame_start;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  // slave: the decoder itself
  modport slave (
    input  in_data, in_valid, frame_start, out_ready,
    output in_ready, out_data, out_valid
  );

  // master: the surrounding source/sink environment
  modport master (
    output in_data, in_valid, frame_start, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/xor_stream_decoder.sv
`default_nettype none
// =============================================================================
// xor_stream_decoder : recovers x[n] = y[n] ^ x[n-1] ^ KEY from a keyed XOR stream.
// Optional macro XOR_DEC_WRAP_FLAG_EN adds a sticky count_wrapped output.
// Revision 1.0
// =============================================================================
module xor_stream_decoder #(
  parameter int unsigned      WIDTH = 8,
  parameter logic [WIDTH-1:0] KEY   = WIDTH'(8'd17),
  parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h03)
) (
  input  wire logic           clk,
  input  wire logic           clear,
  xor_stream_decoder_if.slave bus,
  output logic [15:0]         sym_count
`ifdef XOR_DEC_WRAP_FLAG_EN
  ,
  output logic                count_wrapped
`endif
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_hist;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic [15:0]      r_sym_count;
`ifdef XOR_DEC_WRAP_FLAG_EN
  logic             r_count_wrapped;
`endif

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_prev;
  logic [WIDTH-1:0] w_decoded;

  // The output stage can take a new symbol whenever it is empty or draining.
  assign w_in_ready = !r_out_valid || bus.out_ready;
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_prev     = (bus.frame_start || (r_state == IDLE)) ? SEED : r_hist;
  assign w_decoded  = bus.in_data ^ w_prev ^ KEY;

  always_ff @(posedge clk) begin
    if (clear) begin
      r_state     <= IDLE;
      r_hist      <= SEED;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_sym_count <= 16'd0;
`ifdef XOR_DEC_WRAP_FLAG_EN
      r_count_wrapped <= 1'b0;
`endif
    end else if (w_accept) begin
      r_state     <= RUN;
      r_hist      <= w_decoded;
      r_out_data  <= w_decoded;
      r_out_valid <= 1'b1;
      r_sym_count <= r_sym_count + 16'd1;
`ifdef XOR_DEC_WRAP_FLAG_EN
      if (r_sym_count == 16'hFFFF) begin
        r_count_wrapped <= 1'b1;
      end
`endif
    end else if (bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_data  = r_out_data;
  assign bus.out_valid = r_out_valid;
  assign sym_count     = r_sym_count;
`ifdef XOR_DEC_WRAP_FLAG_EN
  assign count_wrapped = r_count_wrapped;
`endif

endmodule
`default_nettype wire

// File: tb/tb_xor_stream_decoder.sv
`default_nettype none
// =============================================================================
// tb_xor_stream_decoder : scoreboard bench driving a reference keyed-XOR encoder.
// Revision 1.0
// =============================================================================
module tb_xor_stream_decoder;

  localparam logic [7:0] c_KEY  = 8'h11;
  localparam logic [7:0] c_SEED = 8'h03;

  logic        clk;
  logic        clear;
  logic [15:0] sym_count;
`ifdef XOR_DEC_WRAP_FLAG_EN
  logic        count_wrapped;
`endif

  xor_stream_decoder_if #(.WIDTH(8)) bus ();

  xor_stream_decoder #(
    .WIDTH (8),
    .KEY   (c_KEY),
    .SEED  (c_SEED)
  ) dut (
    .clk           (clk),
    .clear         (clear),
    .bus           (bus.slave),
    .sym_count     (sym_count)
`ifdef XOR_DEC_WRAP_FLAG_EN
    ,
    .count_wrapped (count_wrapped)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  logic [7:0]  exp_q[$];
  logic [15:0] model_cnt;
  logic [7:0]  enc_prev;
  bit          rdy_rand;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference encoder: y[n] = x[n] ^ x[n-1] ^ KEY, history restarts at SEED.
  task automatic encode(input logic [7:0] x, input logic fs, output logic [7:0] y);
    logic [7:0] h;
    h        = fs ? c_SEED : enc_prev;
    y        = x ^ h ^ c_KEY;
    enc_prev = x;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [7:0] y, input logic fs, input logic [7:0] x_exp);
    int waited;
    waited          = 0;
    bus.in_valid    = 1'b1;
    bus.in_data     = y;
    bus.frame_start = fs;
    forever begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) break;
      waited++;
      if (waited > 1000) begin
        n_cmp++;
        n_err++;
        $display("FAIL accept_timeout: got in_ready=%b, expected 1 within 1000 cycles", bus.in_ready);
        @(posedge clk);
        #1;
        bus.in_valid    = 1'b0;
        bus.frame_start = 1'b0;
        return;
      end
    end
    exp_q.push_back(x_exp);
    model_cnt = model_cnt + 16'd1;
    @(posedge clk);
    #1;
    bus.in_valid    = 1'b0;
    bus.frame_start = 1'b0;
    chk("sym_count", {16'd0, sym_count}, {16'd0, model_cnt});
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear     = 1'b0;
    exp_q.delete();
    model_cnt = 16'd0;
    enc_prev  = c_SEED;
  endtask

  task automatic monitor();
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!clear && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL out_beat: got unexpected data %h, expected no beat", bus.out_data);
        end else begin
          e = exp_q.pop_front();
          chk("out_data", {24'd0, bus.out_data}, {24'd0, e});
        end
      end
    end
  endtask

  task automatic rdy_gen();
    forever begin
      @(posedge clk);
      #1;
      if (rdy_rand) bus.out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    logic [7:0] x;
    logic [7:0] y;
    logic       fs;
    n_cmp           = 0;
    n_err           = 0;
    model_cnt       = 16'd0;
    enc_prev        = c_SEED;
    rdy_rand        = 1'b0;
    clear           = 1'b1;
    bus.in_valid    = 1'b0;
    bus.in_data     = 8'h00;
    bus.frame_start = 1'b0;
    bus.out_ready   = 1'b1;
    fork
      monitor();
      rdy_gen();
    join_none

    repeat (3) @(posedge clk);
    #1;
    clear = 1'b0;
    chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("reset_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("reset_sym_count", {16'd0, sym_count}, 32'd0);
    chk("reset_in_ready", {31'd0, bus.in_ready}, 32'd1);
`ifdef XOR_DEC_WRAP_FLAG_EN
    chk("reset_wrapped", {31'd0, count_wrapped}, 32'd0);
`endif

    // Directed stream and backpressure
    send(8'h12, 1'b0, 8'h00);
    send(8'hAB, 1'b0, 8'hBA);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h55;
    repeat (3) begin
      @(negedge clk);
      chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("bp_out_data", {24'd0, bus.out_data}, 32'h0000_00BA);
      chk("bp_sym_count", {16'd0, sym_count}, 32'd2);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    send(8'h55, 1'b0, 8'hFE);

    // Frame resync in RUN
    send(8'h12, 1'b1, 8'h00);
    send(8'h11, 1'b0, 8'h00);

    // Clear mid-stream with a pending symbol
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h77;
    do_clear();
    bus.in_valid = 1'b0;
    chk("clr_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("clr_out_data", {24'd0, bus.out_data}, 32'd0);
    chk("clr_sym_count", {16'd0, sym_count}, 32'd0);
    chk("clr_in_ready", {31'd0, bus.in_ready}, 32'd1);
    send(8'h12, 1'b0, 8'h00);

    // Counter wrap over 65536 back-to-back symbols
    do_clear();
    for (int i = 0; i < 65536; i++) begin
      x  = 8'($urandom);
      fs = ($urandom_range(0, 63) == 0);
      encode(x, fs, y);
      send(y, fs, x);
`ifdef XOR_DEC_WRAP_FLAG_EN
      if (i == 65534) chk("wrap_flag_before", {31'd0, count_wrapped}, 32'd0);
      if (i == 65535) chk("wrap_flag_set", {31'd0, count_wrapped}, 32'd1);
`endif
    end
    chk("wrap_sym_count", {16'd0, sym_count}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      x = 8'($urandom);
      encode(x, 1'b0, y);
      send(y, 1'b0, x);
    end
`ifdef XOR_DEC_WRAP_FLAG_EN
    chk("wrap_flag_sticky", {31'd0, count_wrapped}, 32'd1);
`endif
    do_clear();
`ifdef XOR_DEC_WRAP_FLAG_EN
    chk("wrap_flag_clear", {31'd0, count_wrapped}, 32'd0);
`endif

    // Random stream with input gaps and output backpressure
    rdy_rand = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        bus.in_valid    = 1'b0;
        bus.in_data     = 8'($urandom);
        bus.frame_start = 1'($urandom);
        @(posedge clk);
        #1;
      end
      x  = 8'($urandom);
      fs = ($urandom_range(0, 7) == 0);
      encode(x, fs, y);
      send(y, fs, x);
    end

    rdy_rand      = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk("drain_queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/xor_stream_decoder.md
Name: xor_stream_decoder

Overview:
- Receive-side decoder for the team's 8-bit differential-XOR keyed stream encoding. The encoder emits y[n] = x[n] ^ x[n-1] ^ KEY, with x[-1] = SEED after clear.
- This block recovers x[n] = y[n] ^ x[n-1] ^ KEY.
- Sits between the encoded-stream source and downstream logic, with valid/ready handshakes on both sides.
- Has a one-deep registered output stage, a frame-resync input and a 16-bit accepted-symbol counter.

Parameters:
- WIDTH, 8, data width of encoded and decoded symbols.
- KEY, 8'd17, XOR key; must match the encoder's constant. Width WIDTH; upper bits are zero-extended if WIDTH > 8.
- SEED, 8'h03, history value loaded on clear and on frame_start. Same width rules as KEY.

Ports:
- clk  input  1  single clock; all state updates on posedge clk.
- clear  input  1  synchronous, active-high reset; takes effect at posedge clk.
- in_data  input  WIDTH  encoded symbol y[n].
- in_valid  input  1  in_data is valid.
- in_ready  output  1  decoder can accept a symbol this cycle.
- frame_start  input  1  qualifies the current input symbol as first of a frame; sampled only on accept.
- out_data  output  WIDTH  decoded symbol x[n], registered.
- out_valid  output  1  out_data is valid.
- out_ready  input  1  downstream accepts out_data this cycle.
- sym_count  output  16  number of symbols accepted since clear, registered.

Behaviour:
- Reset (clear=1 at posedge): out_data=0, out_valid=0, sym_count=0, hist=SEED, state=IDLE.
- clear dominates every other input in the same cycle, including a pending accept or a held output, which is dropped.
- in_ready is combinational: in_ready = !out_valid || out_ready. It is 1 during the cycle after clear.
- Accept when in_valid && in_ready. Then:
  - On that edge, out_data <= in_data ^ h ^ KEY, where h = SEED if frame_start==1 or state==IDLE, else hist.
  - hist <= the new out_data value; out_valid <= 1; sym_count <= sym_count + 1.
- sym_count wraps modulo 2^16: 16'hFFFF -> 16'h0000.
- Latency: symbol accepted at edge k appears on out_data/out_valid right after edge k (1 cycle).
- Full throughput: one symbol per cycle while out_ready=1.
- No accept and out_ready=1: out_valid <= 0; out_data holds its last value.
- No accept and out_ready=0: out_valid and out_data hold. This is backpressure; in_ready=0 while out_valid=1.
- in_valid=0: no history, counter or state change.
- State machine:
  - IDLE: no symbol accepted since clear.
  - RUN: the first accept moves IDLE -> RUN; RUN has no exit except clear.
  - In RUN, frame_start=1 on accept reseeds the history for that symbol only. The state stays RUN.
- frame_start with no accept is ignored.
- Arithmetic is pure bitwise XOR at WIDTH bits; no carries.

Optional Feature:
- Macro XOR_DEC_WRAP_FLAG_EN.
- When defined: adds output port count_wrapped (1 bit, registered).
  - Set to 1 on the accept edge where sym_count goes 16'hFFFF -> 16'h0000.
  - Sticky until clear; reset value 0.
- When undefined: the port is absent and sym_count wraps silently. All other behaviour is identical.

Test Plan:
- Clear, out_ready=1, then feed y = 0x12, 0xAB, 0x55 on consecutive cycles -> out_data = 0x00, 0xBA, 0xFE on consecutive cycles with out_valid=1; sym_count = 1, 2, 3.
- After the out_data=0xBA beat, hold out_ready=0 with in_valid=1, y=0x55 for 3 cycles -> in_ready=0, out_data stays 0xBA, sym_count stays 2. Raise out_ready -> 0xFE follows one cycle later.
- In RUN with hist=0xFE, feed y=0x12 with frame_start=1 -> out_data=0x00 (SEED used). Next y=0x11 without frame_start -> out_data=0x00.
- Mid-stream, assert clear together with in_valid=1 -> out_valid=0, out_data=0, sym_count=0, no accept. Next y=0x12 -> 0x00.
- Feed 65536 symbols continuously -> sym_count=0x0000 after the last symbol. With XOR_DEC_WRAP_FLAG_EN, count_wrapped=1 and stays 1 until clear.
- Random stream x through a reference encoder (KEY=0x11, SEED=0x03), with random in_valid/out_ready gaps -> decoded sequence equals x exactly, with no drops or duplicates.
